// File: rtl/pll_lock_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pll_lock_supervisor_pkg
// Brief    : State encoding and sizing helpers for the PLL lock supervisor.
// Revision : 1.0
// ============================================================================
package pll_lock_supervisor_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // Counter must hold the largest terminal count (max - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int rc_width(input int max_retries);
        return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_1bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_1bit
// Brief    : N-flop single-bit synchroniser, async active-low reset to 0.
// Revision : 1.0
// ============================================================================
module sync_1bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int c_n = (STAGES < 2) ? 2 : STAGES;

    logic [c_n-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[c_n-2:0], d};
        end
    end

    assign q = r_chain[c_n-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Brief    : Sequences PLL reset, qualifies lock, releases system reset,
//            retries on lock timeout and latches a fault after repeated misses.
// Revision : 1.0
// ============================================================================
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               soft_reset_req,
    output logic                               pll_resetb,
    output logic                               sys_rst_n,
    output logic                               ready,
    output logic                               fault,
    output logic [rc_width(MAX_RETRIES)-1:0]   retry_count
);

    localparam int CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES);
    localparam int RC_W  = rc_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  c_rc_max       = RC_W'(MAX_RETRIES);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [RC_W-1:0]  r_rc;
    logic [RC_W-1:0]  w_rc_next;
    logic             w_locked_s;
    logic             w_counting;

    logic r_pll_resetb;
    logic r_sys_rst_n;
    logic r_ready;
    logic r_fault;

    sync_1bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_locked_s)
    );

    always_comb begin
        w_next    = r_state;
        w_rc_next = r_rc;

        case (r_state)
            PLL_RESET: begin
                if (r_cnt == c_rst_last) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = STABLE;
                end else if (r_cnt == c_timeout_last) begin
                    if (r_rc >= c_rc_max) begin
                        w_next = FAULT;
                    end else begin
                        w_next    = PLL_RESET;
                        w_rc_next = r_rc + RC_W'(1);
                    end
                end
            end
            STABLE: begin
                if (!w_locked_s)                   w_next = WAIT_LOCK;
                else if (r_cnt == c_stable_last)   w_next = RUN;
            end
            RUN: begin
                if (!w_locked_s) w_next = PLL_RESET;
            end
            FAULT: begin
                w_next = FAULT;
            end
            default: begin
                w_next = PLL_RESET;
            end
        endcase

        if (w_next == RUN) w_rc_next = '0;

        // Soft restart overrides every other transition in the same cycle.
        if (soft_reset_req) begin
            w_next    = PLL_RESET;
            w_rc_next = '0;
        end
    end

    always_comb begin
        w_counting = (r_state == PLL_RESET) || (r_state == WAIT_LOCK) ||
                     (r_state == STABLE);
        if ((w_next != r_state) || soft_reset_req || !w_counting) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Outputs decode next-state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PLL_RESET;
            r_cnt        <= '0;
            r_rc         <= '0;
            r_pll_resetb <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_rc         <= w_rc_next;
            r_pll_resetb <= !((w_next == PLL_RESET) || (w_next == FAULT));
            r_sys_rst_n  <= (w_next == RUN);
            r_ready      <= (w_next == RUN);
            r_fault      <= (w_next == FAULT);
        end
    end

    assign pll_resetb  = r_pll_resetb;
    assign sys_rst_n   = r_sys_rst_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_rc;

endmodule
`default_nettype wire
